// File: rtl/io_supply_seq_pkg.sv
// Shared types for the VDDIO supply sequencer.
//  - 3-bit state encodings and the io_seq_state_e enum built on them.
//  - io_seq_out_t: the registered output bundle, plus a decoder that maps a
//    state onto that bundle. The top loads its output registers through this
//    decoder.
package io_supply_seq_pkg;

    localparam logic [2:0] ENC_OFF      = 3'd0;
    localparam logic [2:0] ENC_DEBOUNCE = 3'd1;
    localparam logic [2:0] ENC_RET_HOLD = 3'd2;
    localparam logic [2:0] ENC_RELEASE  = 3'd3;
    localparam logic [2:0] ENC_ACTIVE   = 3'd4;
    localparam logic [2:0] ENC_DISABLE  = 3'd5;
    localparam logic [2:0] ENC_FAULT    = 3'd6;

    typedef enum logic [2:0] {
        ST_OFF      = ENC_OFF,
        ST_DEBOUNCE = ENC_DEBOUNCE,
        ST_RET_HOLD = ENC_RET_HOLD,
        ST_RELEASE  = ENC_RELEASE,
        ST_ACTIVE   = ENC_ACTIVE,
        ST_DISABLE  = ENC_DISABLE,
        ST_FAULT    = ENC_FAULT
    } io_seq_state_e;

    typedef struct packed {
        logic ret;
        logic oe;
        logic ready;
        logic fault;
    } io_seq_out_t;

    // Pads are released only in RELEASE, ACTIVE and DISABLE. Output enable
    // is on only in ACTIVE. The fault flag is high exactly while in FAULT,
    // so it clears on the same edge the FSM leaves FAULT.
    function automatic io_seq_out_t decode_outputs(input io_seq_state_e st);
        io_seq_out_t o;
        o.ret   = !(st == ST_RELEASE || st == ST_ACTIVE || st == ST_DISABLE);
        o.oe    = (st == ST_ACTIVE);
        o.ready = (st == ST_ACTIVE);
        o.fault = (st == ST_FAULT);
        return o;
    endfunction

endpackage

// File: rtl/io_sync_ff.sv
// Multi-flop synchronizer for a single asynchronous level.
// Ports:
//  clk    in  1  destination clock
//  rst_n  in  1  synchronous, active-low reset (chain clears to 0)
//  d      in  1  asynchronous input
//  q      out 1  synchronized output (last stage)
module io_sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/io_supply_sequencer.sv
// Sequencer for the 3.3V VDDIO supply pads in the IO ring.
// It debounces the VDDIO power-good flag, then controls pad retention and
// the global pad output enable. It also gives the core a ready/fault
// handshake.
// Ports:
//  clk          in  1  core clock
//  rst_n        in  1  synchronous, active-low reset
//  vddio_ok_i   in  1  asynchronous power-good, 1 = supply in range
//  io_en_req_i  in  1  level, core requests IO operation
//  fault_clr_i  in  1  pulse, clears the sticky fault (FAULT state only)
//  pad_ret_o    out 1  1 = pads held in retention/isolation
//  pad_oe_en_o  out 1  global pad output enable
//  io_ready_o   out 1  IO ring usable (ACTIVE)
//  fault_o      out 1  sticky, supply lost while released or active
//  state_o      out 3  current FSM state (debug)
module io_supply_sequencer
    import io_supply_seq_pkg::*;
#(
    parameter int DEB_CYCLES    = 1024,
    parameter int SETTLE_CYCLES = 64,
    parameter int SYNC_STAGES   = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       vddio_ok_i,
    input  logic       io_en_req_i,
    input  logic       fault_clr_i,
    output logic       pad_ret_o,
    output logic       pad_oe_en_o,
    output logic       io_ready_o,
    output logic       fault_o,
    output logic [2:0] state_o
);

    localparam int CNT_MAX = (DEB_CYCLES > SETTLE_CYCLES) ? DEB_CYCLES : SETTLE_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] DEB_LOAD    = CNT_W'(DEB_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);

    logic             ok_s;
    io_seq_state_e    state;
    io_seq_state_e    state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    io_seq_out_t      out_nxt;

    io_sync_ff #(.STAGES(SYNC_STAGES)) u_ok_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (vddio_ok_i),
        .q     (ok_s)
    );

    // Next-state logic. Supply loss is tested first in every state, so it
    // takes priority over request-driven and count-driven transitions.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_OFF: begin
                if (ok_s) state_nxt = ST_DEBOUNCE;
            end
            ST_DEBOUNCE: begin
                if (!ok_s)          state_nxt = ST_OFF;
                else if (cnt == '0) state_nxt = ST_RET_HOLD;
            end
            ST_RET_HOLD: begin
                if (!ok_s)                         state_nxt = ST_OFF;
                else if (io_en_req_i && !fault_o)  state_nxt = ST_RELEASE;
            end
            ST_RELEASE: begin
                if (!ok_s)          state_nxt = ST_FAULT;
                else if (cnt == '0) state_nxt = ST_ACTIVE;
            end
            ST_ACTIVE: begin
                if (!ok_s)             state_nxt = ST_FAULT;
                else if (!io_en_req_i) state_nxt = ST_DISABLE;
            end
            ST_DISABLE: begin
                if (!ok_s)          state_nxt = ST_FAULT;
                else if (cnt == '0) state_nxt = ST_RET_HOLD;
            end
            ST_FAULT: begin
                if (fault_clr_i) state_nxt = ok_s ? ST_RET_HOLD : ST_OFF;
            end
            default: state_nxt = ST_OFF;
        endcase
    end

    // Shared down-counter. It is loaded when a counting state is entered.
    // Otherwise it counts down and holds at 0 (never wraps).
    always_comb begin
        cnt_nxt = cnt;
        if (state_nxt != state) begin
            case (state_nxt)
                ST_DEBOUNCE:           cnt_nxt = DEB_LOAD;
                ST_RELEASE, ST_DISABLE: cnt_nxt = SETTLE_LOAD;
                default:               cnt_nxt = '0;
            endcase
        end else if (cnt != '0) begin
            cnt_nxt = cnt - CNT_W'(1);
        end
    end

    assign out_nxt = decode_outputs(state_nxt);

    // The outputs are decoded from the next state, so they change on the
    // same edge as the state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= ST_OFF;
            cnt         <= '0;
            pad_ret_o   <= 1'b1;
            pad_oe_en_o <= 1'b0;
            io_ready_o  <= 1'b0;
            fault_o     <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            pad_ret_o   <= out_nxt.ret;
            pad_oe_en_o <= out_nxt.oe;
            io_ready_o  <= out_nxt.ready;
            fault_o     <= out_nxt.fault;
        end
    end

    assign state_o = state;

endmodule

// File: tb/tb_io_supply_sequencer.sv
// Directed bench for io_supply_sequencer with DEB_CYCLES=8, SETTLE_CYCLES=4.
module tb_io_supply_sequencer;

    logic       clk;
    logic       rst_n;
    logic       vddio_ok_i;
    logic       io_en_req_i;
    logic       fault_clr_i;
    logic       pad_ret_o;
    logic       pad_oe_en_o;
    logic       io_ready_o;
    logic       fault_o;
    logic [2:0] state_o;

    int n_tests;
    int n_fail;

    io_supply_sequencer #(
        .DEB_CYCLES    (8),
        .SETTLE_CYCLES (4),
        .SYNC_STAGES   (2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .vddio_ok_i  (vddio_ok_i),
        .io_en_req_i (io_en_req_i),
        .fault_clr_i (fault_clr_i),
        .pad_ret_o   (pad_ret_o),
        .pad_oe_en_o (pad_oe_en_o),
        .io_ready_o  (io_ready_o),
        .fault_o     (fault_o),
        .state_o     (state_o)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance n rising edges, then sit 1ns past the last edge. Inputs are
    // driven and outputs sampled there.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ret, oe, ready, fault, state in one call
    task automatic check_all(input string tag, input logic r, input logic o,
                             input logic y, input logic f, input logic [2:0] s);
        check({tag, ".state"}, {5'd0, state_o}, {5'd0, s});
        check({tag, ".ret"},   {7'd0, pad_ret_o},   {7'd0, r});
        check({tag, ".oe"},    {7'd0, pad_oe_en_o}, {7'd0, o});
        check({tag, ".ready"}, {7'd0, io_ready_o},  {7'd0, y});
        check({tag, ".fault"}, {7'd0, fault_o},     {7'd0, f});
    endtask

    initial begin
        n_tests     = 0;
        n_fail      = 0;
        rst_n       = 1'b0;
        vddio_ok_i  = 1'b0;
        io_en_req_i = 1'b0;
        fault_clr_i = 1'b0;
        tick(2);
        check_all("reset", 1, 0, 0, 0, 3'd0);
        rst_n = 1'b1;

        // Glitch: 5 cycles high. The sync takes 2 edges, DEBOUNCE is entered
        // on edge 3, the low reaches ok_s after edge 7, and OFF follows on edge 8.
        vddio_ok_i = 1'b1;
        tick(5);
        vddio_ok_i = 1'b0;
        tick(2);
        check("glitch.debounce", {5'd0, state_o}, 8'd1);
        tick(1);
        check_all("glitch.off", 1, 0, 0, 0, 3'd0);

        // Power-up: RET_HOLD after 2+8+1 = 11 edges.
        vddio_ok_i = 1'b1;
        tick(10);
        check("pwrup.edge10", {5'd0, state_o}, 8'd1);
        tick(1);
        check_all("pwrup.ret_hold", 1, 0, 0, 0, 3'd2);

        // fault_clr outside FAULT does nothing.
        fault_clr_i = 1'b1;
        tick(1);
        fault_clr_i = 1'b0;
        check_all("clr_idle", 1, 0, 0, 0, 3'd2);

        // Enable, with a req glitch inside RELEASE.
        io_en_req_i = 1'b1;
        tick(1);
        check_all("enable.release", 0, 0, 0, 0, 3'd3);
        io_en_req_i = 1'b0;
        tick(1);
        io_en_req_i = 1'b1;
        tick(2);
        check_all("enable.edge3", 0, 0, 0, 0, 3'd3);
        tick(1);
        check_all("enable.active", 0, 1, 1, 0, 3'd4);

        // Disable, with a req glitch inside DISABLE.
        io_en_req_i = 1'b0;
        tick(1);
        check_all("disable.enter", 0, 0, 0, 0, 3'd5);
        io_en_req_i = 1'b1;
        tick(1);
        io_en_req_i = 1'b0;
        tick(2);
        check_all("disable.edge3", 0, 0, 0, 0, 3'd5);
        tick(1);
        check_all("disable.ret_hold", 1, 0, 0, 0, 3'd2);

        // Back to ACTIVE, then lose the supply.
        io_en_req_i = 1'b1;
        tick(5);
        check_all("reactive", 0, 1, 1, 0, 3'd4);
        vddio_ok_i = 1'b0;
        tick(2);
        check("loss.pre", {5'd0, state_o}, 8'd4);
        tick(1);
        check_all("loss.fault", 1, 0, 0, 1, 3'd6);
        // A req pulse while faulted is ignored.
        io_en_req_i = 1'b0;
        tick(1);
        io_en_req_i = 1'b1;
        tick(1);
        io_en_req_i = 1'b0;
        vddio_ok_i  = 1'b1;
        tick(3);
        check_all("loss.sticky", 1, 0, 0, 1, 3'd6);
        fault_clr_i = 1'b1;
        tick(1);
        fault_clr_i = 1'b0;
        check_all("loss.cleared", 1, 0, 0, 0, 3'd2);
        tick(2);
        check_all("loss.no_autorel", 1, 0, 0, 0, 3'd2);

        // Loss in RET_HOLD goes to OFF without a fault.
        vddio_ok_i = 1'b0;
        tick(3);
        check_all("rh_loss", 1, 0, 0, 0, 3'd0);

        // A fault cleared while the supply is still absent goes to OFF.
        vddio_ok_i = 1'b1;
        tick(11);
        check("rh_loss.back", {5'd0, state_o}, 8'd2);
        io_en_req_i = 1'b1;
        tick(1);
        vddio_ok_i = 1'b0;
        tick(3);
        check_all("fault2", 1, 0, 0, 1, 3'd6);
        io_en_req_i = 1'b0;
        fault_clr_i = 1'b1;
        tick(1);
        fault_clr_i = 1'b0;
        check_all("fault2.clr_off", 1, 0, 0, 0, 3'd0);

        // Reset during RELEASE with cnt=2.
        vddio_ok_i = 1'b1;
        tick(11);
        check("rst_mid.ret_hold", {5'd0, state_o}, 8'd2);
        io_en_req_i = 1'b1;
        tick(2);
        check("rst_mid.release", {5'd0, state_o}, 8'd3);
        rst_n = 1'b0;
        tick(1);
        check_all("rst_mid", 1, 0, 0, 0, 3'd0);
        rst_n       = 1'b1;
        io_en_req_i = 1'b0;
        // The sync chain was also cleared, so DEBOUNCE starts on edge 3 again.
        tick(2);
        check("rst_mid.sync", {5'd0, state_o}, 8'd0);
        tick(1);
        check("rst_mid.deb", {5'd0, state_o}, 8'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
